// File: rtl/time_field_counter.sv
// rtl/time_field_counter.sv - one field of a clock/alarm chain with carry, alarm match and BCD display
module time_field_counter #(
  parameter int WIDTH   = 6,
  parameter int MODULUS = 24,
  parameter int MIN_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             set_en,
  input  logic [WIDTH-1:0] set_val,
  input  logic             alarm_wr,
  input  logic [WIDTH-1:0] alarm_val,
  input  logic             alarm_en,
  input  logic             show_alarm,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] alarm_reg,
  output logic             carry_out,
  output logic             alarm_hit,
  output logic             set_err,
  output logic [3:0]       digit0,
  output logic [3:0]       digit1
);

  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MIN_VAL + MODULUS - 1);
  localparam logic [WIDTH:0]   MIN_X = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);

  // Range check as an offset from MIN_VAL: values below MIN_VAL wrap to a
  // large offset in the extra bit, so a single unsigned compare covers both ends.
  function automatic logic is_legal(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] off;
    off = {1'b0, v} - MIN_X;
    return off < MOD_X;
  endfunction

  logic             set_ok;
  logic             alarm_ok;
  logic             wrap;
  logic [WIDTH-1:0] next_tick;
  logic [WIDTH-1:0] src;

  // Legality of the load values, tick successor and display source selection
  always_comb begin
    set_ok    = is_legal(set_val);
    alarm_ok  = is_legal(alarm_val);
    wrap      = (value == MAX_V);
    next_tick = wrap ? MIN_V : value + 1'b1;
    src       = show_alarm ? alarm_reg : value;
  end

  // Live value with set-over-tick priority; carry and alarm match only on ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      value     <= MIN_V;
      carry_out <= 1'b0;
      alarm_hit <= 1'b0;
    end else begin
      carry_out <= 1'b0;
      alarm_hit <= 1'b0;
      if (set_en) begin
        if (set_ok) begin
          value <= set_val;
        end
      end else if (tick_in) begin
        value     <= next_tick;
        carry_out <= wrap;
        alarm_hit <= alarm_en && (next_tick == alarm_reg);
      end
    end
  end

  // Alarm register, compared above before any same-cycle write lands
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_reg <= MIN_V;
    end else if (alarm_wr && alarm_ok) begin
      alarm_reg <= alarm_val;
    end
  end

  // Single error pulse when either load of this cycle is out of range
  always_ff @(posedge clk) begin
    if (rst) begin
      set_err <= 1'b0;
    end else begin
      set_err <= (set_en && !set_ok) || (alarm_wr && !alarm_ok);
    end
  end

  // BCD digits registered from the current registered source
  always_ff @(posedge clk) begin
    if (rst) begin
      digit0 <= 4'd0;
      digit1 <= 4'd0;
    end else begin
      digit0 <= 4'(src % 10);
      digit1 <= 4'(src / 10);
    end
  end

endmodule

// File: tb/tb_time_field_counter.sv
// tb/tb_time_field_counter.sv - self-checking bench for time_field_counter (hour and day-of-month fields)
module tb_time_field_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance a: hours (WIDTH 6, MODULUS 24, MIN_VAL 0)
  logic       a_rst, a_tick, a_set_en, a_alarm_wr, a_alarm_en, a_show;
  logic [5:0] a_set_val, a_alarm_val, a_value, a_alarm_reg;
  logic       a_carry, a_hit, a_err;
  logic [3:0] a_d0, a_d1;

  // instance b: day of month (WIDTH 5, MODULUS 31, MIN_VAL 1)
  logic       b_rst, b_tick, b_set_en, b_alarm_wr, b_alarm_en, b_show;
  logic [4:0] b_set_val, b_alarm_val, b_value, b_alarm_reg;
  logic       b_carry, b_hit, b_err;
  logic [3:0] b_d0, b_d1;

  time_field_counter #(.WIDTH(6), .MODULUS(24), .MIN_VAL(0)) dut_a (
    .clk(clk), .rst(a_rst), .tick_in(a_tick), .set_en(a_set_en), .set_val(a_set_val),
    .alarm_wr(a_alarm_wr), .alarm_val(a_alarm_val), .alarm_en(a_alarm_en), .show_alarm(a_show),
    .value(a_value), .alarm_reg(a_alarm_reg), .carry_out(a_carry), .alarm_hit(a_hit),
    .set_err(a_err), .digit0(a_d0), .digit1(a_d1)
  );

  time_field_counter #(.WIDTH(5), .MODULUS(31), .MIN_VAL(1)) dut_b (
    .clk(clk), .rst(b_rst), .tick_in(b_tick), .set_en(b_set_en), .set_val(b_set_val),
    .alarm_wr(b_alarm_wr), .alarm_val(b_alarm_val), .alarm_en(b_alarm_en), .show_alarm(b_show),
    .value(b_value), .alarm_reg(b_alarm_reg), .carry_out(b_carry), .alarm_hit(b_hit),
    .set_err(b_err), .digit0(b_d0), .digit1(b_d1)
  );

  int checks = 0;
  int errors = 0;

  int mn [2] = '{0, 1};
  int mx [2] = '{23, 31};
  int m_val [2], m_al [2], m_carry [2], m_hit [2], m_err [2], m_d0 [2], m_d1 [2];
  bit m_valid [2] = '{1'b0, 1'b0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: the field as plain integers, one clock edge per call
  task automatic model(input int k, input bit r, input bit tk, input bit se, input int sv,
                       input bit aw, input int av, input bit ae, input bit sh);
    bit sok, aok;
    int src;
    if (r) begin
      m_val[k] = mn[k]; m_al[k] = mn[k];
      m_carry[k] = 0; m_hit[k] = 0; m_err[k] = 0; m_d0[k] = 0; m_d1[k] = 0;
      m_valid[k] = 1'b1;
      return;
    end
    sok = (sv >= mn[k]) && (sv <= mx[k]);
    aok = (av >= mn[k]) && (av <= mx[k]);
    src = sh ? m_al[k] : m_val[k];
    m_d0[k] = src % 10;
    m_d1[k] = src / 10;
    m_err[k] = (se && !sok) || (aw && !aok);
    m_carry[k] = 0;
    m_hit[k] = 0;
    if (se) begin
      if (sok) m_val[k] = sv;
    end else if (tk) begin
      if (m_val[k] == mx[k]) begin
        m_val[k] = mn[k];
        m_carry[k] = 1;
      end else begin
        m_val[k] = m_val[k] + 1;
      end
      m_hit[k] = ae && (m_val[k] == m_al[k]);
    end
    if (aw && aok) m_al[k] = av;
  endtask

  // One clock: model advances on the edge, outputs compared 2ns later, pulses dropped
  task automatic step();
    @(posedge clk);
    model(0, a_rst, a_tick, a_set_en, int'(a_set_val), a_alarm_wr, int'(a_alarm_val), a_alarm_en, a_show);
    model(1, b_rst, b_tick, b_set_en, int'(b_set_val), b_alarm_wr, int'(b_alarm_val), b_alarm_en, b_show);
    #2;
    if (m_valid[0]) begin
      chk("a.value", a_value, m_val[0]);
      chk("a.alarm_reg", a_alarm_reg, m_al[0]);
      chk("a.carry_out", a_carry, m_carry[0]);
      chk("a.alarm_hit", a_hit, m_hit[0]);
      chk("a.set_err", a_err, m_err[0]);
      chk("a.digit0", a_d0, m_d0[0]);
      chk("a.digit1", a_d1, m_d1[0]);
    end
    if (m_valid[1]) begin
      chk("b.value", b_value, m_val[1]);
      chk("b.alarm_reg", b_alarm_reg, m_al[1]);
      chk("b.carry_out", b_carry, m_carry[1]);
      chk("b.alarm_hit", b_hit, m_hit[1]);
      chk("b.set_err", b_err, m_err[1]);
      chk("b.digit0", b_d0, m_d0[1]);
      chk("b.digit1", b_d1, m_d1[1]);
    end
    a_rst = 0; a_tick = 0; a_set_en = 0; a_alarm_wr = 0;
    b_rst = 0; b_tick = 0; b_set_en = 0; b_alarm_wr = 0;
  endtask

  initial begin
    a_rst = 1; a_tick = 0; a_set_en = 0; a_set_val = '0; a_alarm_wr = 0; a_alarm_val = '0;
    a_alarm_en = 0; a_show = 0;
    b_rst = 1; b_tick = 0; b_set_en = 0; b_set_val = '0; b_alarm_wr = 0; b_alarm_val = '0;
    b_alarm_en = 0; b_show = 0;
    step();
    chk("lit reset value", a_value, 0);
    chk("lit reset alarm", a_alarm_reg, 0);
    chk("lit reset carry", a_carry, 0);
    chk("lit reset digits", {a_d1, a_d0}, 0);
    chk("lit reset b value", b_value, 1);

    // 23 ticks reach MAX, the 24th wraps with a single carry
    for (int i = 0; i < 23; i++) begin
      a_tick = 1; step();
    end
    chk("lit value 23", a_value, 23);
    chk("lit no carry at 23", a_carry, 0);
    a_tick = 1; step();
    chk("lit wrap value", a_value, 0);
    chk("lit wrap carry", a_carry, 1);
    step();
    chk("lit carry one cycle", a_carry, 0);
    chk("lit wrap digit0", a_d0, 0);
    chk("lit wrap digit1", a_d1, 0);

    // set beats tick in the same cycle
    a_set_en = 1; a_set_val = 17; a_tick = 1; step();
    chk("lit set 17 value", a_value, 17);
    chk("lit set 17 carry", a_carry, 0);
    chk("lit set 17 hit", a_hit, 0);
    step();
    chk("lit set 17 digit1", a_d1, 1);
    chk("lit set 17 digit0", a_d0, 7);

    // illegal loads
    a_set_en = 1; a_set_val = 30; step();
    chk("lit bad set value", a_value, 17);
    chk("lit bad set err", a_err, 1);
    step();
    chk("lit err one cycle", a_err, 0);
    a_alarm_wr = 1; a_alarm_val = 25; step();
    chk("lit bad alarm reg", a_alarm_reg, 0);
    chk("lit bad alarm err", a_err, 1);

    // tick-driven alarm match, set-driven non-match, disabled alarm
    a_alarm_wr = 1; a_alarm_val = 6; a_alarm_en = 1; step();
    chk("lit alarm 6", a_alarm_reg, 6);
    a_set_en = 1; a_set_val = 5; step();
    a_tick = 1; step();
    chk("lit tick to 6", a_value, 6);
    chk("lit alarm hit", a_hit, 1);
    step();
    chk("lit hit one cycle", a_hit, 0);
    a_set_en = 1; a_set_val = 5; step();
    a_set_en = 1; a_set_val = 6; step();
    chk("lit set to 6 no hit", a_hit, 0);
    a_alarm_en = 0;
    a_set_en = 1; a_set_val = 5; step();
    a_tick = 1; step();
    chk("lit disabled value", a_value, 6);
    chk("lit disabled no hit", a_hit, 0);

    // display source selection
    a_set_en = 1; a_set_val = 12; step();
    a_show = 1; step();
    chk("lit show alarm d1", a_d1, 0);
    chk("lit show alarm d0", a_d0, 6);
    a_show = 0; step();
    chk("lit show value d1", a_d1, 1);
    chk("lit show value d0", a_d0, 2);

    // day-of-month field boundaries
    b_set_en = 1; b_set_val = 31; step();
    b_tick = 1; step();
    chk("lit b wrap value", b_value, 1);
    chk("lit b wrap carry", b_carry, 1);
    b_set_en = 1; b_set_val = 0; step();
    chk("lit b set 0 err", b_err, 1);
    chk("lit b set 0 value", b_value, 1);
    b_set_en = 1; b_set_val = 31; step();
    b_tick = 1; b_rst = 1; step();
    chk("lit b rst value", b_value, 1);
    chk("lit b rst no carry", b_carry, 0);

    // randomized traffic on both fields against the model
    for (int n = 0; n < 3000; n++) begin
      a_rst = ($urandom_range(0, 79) == 0);
      a_tick = $urandom_range(0, 1);
      a_set_en = ($urandom_range(0, 7) == 0);
      a_set_val = 6'($urandom_range(0, 31));
      a_alarm_wr = ($urandom_range(0, 7) == 0);
      a_alarm_val = 6'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) a_alarm_en = ~a_alarm_en;
      if ($urandom_range(0, 5) == 0) a_show = ~a_show;
      b_rst = ($urandom_range(0, 79) == 0);
      b_tick = $urandom_range(0, 1);
      b_set_en = ($urandom_range(0, 7) == 0);
      b_set_val = 5'($urandom_range(0, 31));
      b_alarm_wr = ($urandom_range(0, 7) == 0);
      b_alarm_val = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) b_alarm_en = ~b_alarm_en;
      if ($urandom_range(0, 5) == 0) b_show = ~b_show;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
